// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes and FSM state encoding shared by the load/store unit files.
package lsu_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane extraction/extension and sub-word store merging for a word-only memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);
    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  b;
    logic [15:0] h;
    assign bsh = {off_i, 3'b000};
    assign hsh = {off_i[1], 4'b0000};
    assign b   = 8'(word_i >> bsh);
    assign h   = 16'(word_i >> hsh);
    assign load_o = funct3_i == F3_LB  ? {{24{b[7]}}, b} :
                    funct3_i == F3_LBU ? {24'b0, b} :
                    funct3_i == F3_LH  ? {{16{h[15]}}, h} :
                    funct3_i == F3_LHU ? {16'b0, h} : word_i;
    // Store codes share the low funct3 bits with the signed loads: 000 SB, 001 SH, 010 SW.
    assign store_o = funct3_i == F3_LB ? (old_i & ~(32'h0000_00FF << bsh)) | ({24'b0, wdata_i[7:0]} << bsh) :
                     funct3_i == F3_LH ? (old_i & ~(32'h0000_FFFF << hsh)) | ({16'b0, wdata_i[15:0]} << hsh) :
                     wdata_i;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator to a word-only data memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of ignoring the low bits.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int MEM_AW = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    input  logic [XLEN-1:0] mem_read_data
);
    if (XLEN != 32 || MEM_AW < 1 || MEM_AW > XLEN - 2) begin : g_param_check
        $error("load_store_unit: unsupported XLEN/MEM_AW");
    end

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] old_q, old_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        illegal;
    logic        misaligned;
    logic [31:0] load_val;
    logic [31:0] store_val;

    assign illegal = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_write && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3 == F3_LW && |req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    lsu_align u_align (
        .word_i  (mem_read_data),
        .old_i   (old_q),
        .wdata_i (wdata_q),
        .funct3_i(f3_q),
        .off_i   (addr_q[1:0]),
        .load_o  (load_val),
        .store_o (store_val)
    );

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        // Response registers change only on the edge entering RESP so they hold between responses.
        case (state_q)
            IDLE: if (req_valid) begin
                write_d = req_write;
                f3_d    = req_funct3;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                state_d = (illegal || misaligned) ? RESP : (req_write && req_funct3 == F3_LW) ? WR : RD;
                if (illegal || misaligned) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            RD: begin
                state_d = write_q ? WR : RESP;
                old_d   = write_q ? mem_read_data : old_q;
                rdata_d = write_q ? rdata_q : load_val;
                err_d   = write_q ? err_q : 1'b0;
            end
            WR: begin
                state_d = RESP;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready      = state_q == IDLE;
    assign mem_read       = state_q == RD;
    assign mem_write      = state_q == WR;
    assign mem_address    = {addr_q[31:2], 2'b00};
    assign mem_write_data = mem_write ? store_val : '0;
    assign resp_valid     = state_q == RESP;
    assign resp_rdata     = rdata_q;
    assign resp_error     = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed requests against a word memory model; a monitor scores every response.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          nrd;
        int          nwr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:255];
    exp_t        sbq[$];
    int          cyc = 0;
    int          rd_n = 0;
    int          wr_n = 0;
    int          tests = 0;
    int          fails = 0;

    load_store_unit dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_error    (resp_error),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
    assign mem_read_data = mem[mem_address[9:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rd_n = 0;
            wr_n = 0;
        end else begin
            rd_n += int'(mem_read);
            wr_n += int'(mem_write);
            if (mem_read && mem_write) chk("rd_wr_overlap", 32'(mem_read & mem_write), 32'd0);
            if (resp_valid) begin
                if (sbq.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                else begin
                    e = sbq.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_error", 32'(resp_error), 32'(e.err));
                    chk("latency_cycle", cyc, e.cyc);
                    chk("mem_read_cycles", rd_n, e.nrd);
                    chk("mem_write_cycles", wr_n, e.nwr);
                end
                rd_n = 0;
                wr_n = 0;
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input int lat, input int nrd, input int nwr);
        exp_t e;
        int   k = 0;
        wait_ready();
        drive(w, f3, a, wd);
        e.rdata = er;
        e.err   = ee;
        e.cyc   = cyc + lat - 1;
        e.nrd   = nrd;
        e.nwr   = nwr;
        sbq.push_back(e);
        while (sbq.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) begin
            chk("resp_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_write_data", mem_write_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // reset while an SB sits in WR: the write must be dropped
        do_req(1, F3_LW, 32'h40, 32'h1122_3344, 32'h0, 0, 2, 0, 1);
        wait_ready();
        drive(1, F3_LB, 32'h41, 32'h0000_0099);
        k = 0;
        while (!mem_write && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("reached_wr", 32'(mem_write), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mid_mem_read", 32'(mem_read), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_mem_word", mem[16], 32'h1122_3344);

        do_req(1, F3_LW, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 2, 0, 1);
        chk("mem_sw_10", mem[4], 32'hDEAD_BEEF);
        do_req(0, F3_LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 2, 1, 0);
        repeat (3) @(negedge clk);
        chk("rdata_hold", resp_rdata, 32'hDEAD_BEEF);

        do_req(1, F3_LB, 32'h13, 32'hAAAA_AA80, 32'h0, 0, 3, 1, 1);
        chk("mem_sb_13", mem[4], 32'h80AD_BEEF);
        do_req(0, F3_LB,  32'h13, 32'h0, 32'hFFFF_FF80, 0, 2, 1, 0);
        do_req(0, F3_LBU, 32'h13, 32'h0, 32'h0000_0080, 0, 2, 1, 0);
        do_req(0, F3_LB,  32'h10, 32'h0, 32'hFFFF_FFEF, 0, 2, 1, 0);
        do_req(0, F3_LBU, 32'h11, 32'h0, 32'h0000_00BE, 0, 2, 1, 0);
        do_req(1, F3_LB,  32'h10, 32'h0000_0055, 32'h0, 0, 3, 1, 1);
        chk("mem_sb_10", mem[4], 32'h80AD_BE55);
        do_req(1, F3_LH,  32'h12, 32'h0000_7777, 32'h0, 0, 3, 1, 1);
        chk("mem_sh_12", mem[4], 32'h7777_BE55);
        do_req(0, F3_LH,  32'h12, 32'h0, 32'h0000_7777, 0, 2, 1, 0);
        do_req(0, F3_LW,  32'h10, 32'h0, 32'h7777_BE55, 0, 2, 1, 0);

        do_req(1, F3_LW,  32'h20, 32'h0, 32'h0, 0, 2, 0, 1);
        do_req(1, F3_LH,  32'h22, 32'h0000_1234, 32'h0, 0, 3, 1, 1);
        chk("mem_sh_22", mem[8], 32'h1234_0000);
        do_req(0, F3_LH,  32'h22, 32'h0, 32'h0000_1234, 0, 2, 1, 0);
        do_req(0, F3_LHU, 32'h20, 32'h0, 32'h0000_0000, 0, 2, 1, 0);
        do_req(1, F3_LH,  32'h20, 32'hABCD_8001, 32'h0, 0, 3, 1, 1);
        chk("mem_sh_20", mem[8], 32'h1234_8001);
        do_req(0, F3_LH,  32'h20, 32'h0, 32'hFFFF_8001, 0, 2, 1, 0);
        do_req(0, F3_LHU, 32'h20, 32'h0, 32'h0000_8001, 0, 2, 1, 0);

        do_req(1, F3_LW,  32'h30, 32'h0, 32'h0, 0, 2, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(0, F3_LW,  32'h11, 32'h0, 32'h0, 1, 1, 0, 0);
        do_req(0, F3_LH,  32'h23, 32'h0, 32'h0, 1, 1, 0, 0);
        do_req(1, F3_LW,  32'h32, 32'hCAFE_F00D, 32'h0, 1, 1, 0, 0);
        chk("mem_sw_misaligned", mem[12], 32'h0);
`else
        do_req(0, F3_LW,  32'h11, 32'h0, 32'h7777_BE55, 0, 2, 1, 0);
        do_req(0, F3_LH,  32'h23, 32'h0, 32'h0000_1234, 0, 2, 1, 0);
        do_req(1, F3_LW,  32'h32, 32'hCAFE_F00D, 32'h0, 0, 2, 0, 1);
        chk("mem_sw_misaligned", mem[12], 32'hCAFE_F00D);
`endif

        do_req(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0);
        do_req(0, 3'b110, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0);
        do_req(1, 3'b111, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0);
        do_req(1, F3_LBU, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0);
        do_req(1, F3_LHU, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0);
        chk("mem_after_illegal", mem[4], 32'h7777_BE55);
        do_req(0, F3_LW,  32'h40, 32'h0, 32'h1122_3344, 0, 2, 1, 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
